seq_decoder: RTL and testbench

Parametrised sequential successor to the team's 4-to-16 combinational decoder. Decodes an N-bit index into a 2^N one-hot (or one-cold) output with two modes. Direct mode is a registered load-and-hold decode. Scan mode is an auto-advancing ring with a programmable dwell time and wrap limit, used for digit/row strobing. All outputs come straight from flops, with no combinational input-to-output path.

---
 rtl/seq_decoder.sv | 104 ++++++++++
 tb/tb_seq_decoder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seq_decoder.sv
// rtl/seq_decoder.sv - registered N-to-2^N decoder with direct load and auto-advancing scan ring
//
// Purpose: decodes an index register into a one-hot (or one-cold) output.
//   Direct mode (mode=0) loads sel on load and holds it.
//   Scan mode (mode=1) steps the index every dwell+1 cycles.
//   In scan mode the index wraps to 0 after reaching last, pulsing wrap.
//
// Ports:
//   clk     - system clock, rising edge
//   rst_n   - asynchronous active-low reset
//   en      - block enable; 0 drives all outputs idle
//   mode    - 0 = direct decode, 1 = scan
//   load    - loads sel into idx when en=1 (both modes)
//   sel     - index to load
//   dwell   - scan: cycles per step minus one
//   last    - scan: highest index before wrap to 0
//   Y       - decoded output (active-high, or active-low if ACTIVE_LOW)
//   idx     - current index register
//   active  - 1 when Y carries a selected line
//   wrap    - one-cycle pulse on scan wrap to 0
module seq_decoder #(
  parameter int N          = 4,
  parameter int DW         = 8,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic              load,
  input  logic [N-1:0]      sel,
  input  logic [DW-1:0]     dwell,
  input  logic [N-1:0]      last,
  output logic [(1<<N)-1:0] Y,
  output logic [N-1:0]      idx,
  output logic              active,
  output logic              wrap
);

  localparam int W = 1 << N;

  logic          act;
  logic [DW-1:0] dcnt;
  logic          mode_q;
  logic [W-1:0]  y_hot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      act    <= 1'b0;
      dcnt   <= '0;
      mode_q <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      mode_q <= mode;
      if (!en) begin
        // idx deliberately holds so re-enabling in direct mode needs a fresh load
        act  <= 1'b0;
        dcnt <= '0;
        wrap <= 1'b0;
      end else if (!mode) begin
        if (load) begin
          idx <= sel;
          act <= 1'b1;
        end
        dcnt <= '0;
        wrap <= 1'b0;
      end else begin
        act <= 1'b1;
        if (load) begin
          idx  <= sel;
          dcnt <= '0;
          wrap <= 1'b0;
        end else if (mode != mode_q) begin
          // restart the dwell on entry so the first step is full length
          dcnt <= '0;
          wrap <= 1'b0;
        end else if (dcnt == dwell) begin
          dcnt <= '0;
          // >= also catches idx above a lowered last or an out-of-range load
          if (idx >= last) begin
            idx  <= '0;
            wrap <= 1'b1;
          end else begin
            idx  <= idx + 1'b1;
            wrap <= 1'b0;
          end
        end else begin
          dcnt <= dcnt + 1'b1;
          wrap <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    y_hot = '0;
    if (act) y_hot[idx] = 1'b1;
  end

  assign Y      = ACTIVE_LOW ? ~y_hot : y_hot;
  assign active = act;

endmodule

// File: tb/tb_seq_decoder.sv
// tb/tb_seq_decoder.sv - directed self-checking bench for seq_decoder (active-high and active-low builds)
module tb_seq_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        mode;
  logic        load;
  logic [3:0]  sel;
  logic [7:0]  dwell;
  logic [3:0]  last;
  logic [15:0] y_h;
  logic [3:0]  idx_h;
  logic        active_h;
  logic        wrap_h;
  logic [15:0] y_l;
  logic [3:0]  idx_l;
  logic        active_l;
  logic        wrap_l;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  seq_decoder #(.N(4), .DW(8), .ACTIVE_LOW(1'b0)) dut_h (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .sel(sel),
    .dwell(dwell), .last(last), .Y(y_h), .idx(idx_h), .active(active_h), .wrap(wrap_h)
  );

  seq_decoder #(.N(4), .DW(8), .ACTIVE_LOW(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .sel(sel),
    .dwell(dwell), .last(last), .Y(y_l), .idx(idx_l), .active(active_l), .wrap(wrap_l)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0;
    sel = 4'h0; dwell = 8'd0; last = 4'h0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    vectors++; if (y_h !== 16'h0000) begin errors++; $display("FAIL reset_y: got %h expected 0000", y_h); end
    vectors++; if (y_l !== 16'hFFFF) begin errors++; $display("FAIL reset_y_al: got %h expected ffff", y_l); end
    vectors++; if (idx_h !== 4'h0) begin errors++; $display("FAIL reset_idx: got %h expected 0", idx_h); end
    vectors++; if (active_h !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", active_h); end
    vectors++; if (wrap_h !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b expected 0", wrap_h); end
  endtask

  task automatic test_direct();
    en = 1'b1; mode = 1'b0;
    tick();
    vectors++; if (active_h !== 1'b0) begin errors++; $display("FAIL direct_noload_active: got %b expected 0", active_h); end
    sel = 4'hA; load = 1'b1;
    tick();
    vectors++; if (y_h !== 16'h0400) begin errors++; $display("FAIL direct_load_y: got %h expected 0400", y_h); end
    vectors++; if (active_h !== 1'b1) begin errors++; $display("FAIL direct_load_active: got %b expected 1", active_h); end
    load = 1'b0;
    tick();
    vectors++; if (y_h !== 16'h0400) begin errors++; $display("FAIL direct_hold_y: got %h expected 0400", y_h); end
    sel = 4'h3;
    tick();
    vectors++; if (y_h !== 16'h0400) begin errors++; $display("FAIL direct_sel_noload_y: got %h expected 0400", y_h); end
    vectors++; if (wrap_h !== 1'b0) begin errors++; $display("FAIL direct_wrap: got %b expected 0", wrap_h); end
    en = 1'b0;
    tick();
    vectors++; if (y_h !== 16'h0000) begin errors++; $display("FAIL direct_en_off_y: got %h expected 0000", y_h); end
    vectors++; if (idx_h !== 4'hA) begin errors++; $display("FAIL direct_en_off_idx: got %h expected a", idx_h); end
    vectors++; if (active_h !== 1'b0) begin errors++; $display("FAIL direct_en_off_active: got %b expected 0", active_h); end
    en = 1'b1;
    tick();
    vectors++; if (active_h !== 1'b0) begin errors++; $display("FAIL direct_reenable_active: got %b expected 0", active_h); end
    en = 1'b0;
    tick();
  endtask

  task automatic test_scan_ring();
    int exp_idx [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    logic [15:0] exp_y;
    logic        exp_w;
    en = 1'b1; mode = 1'b1; dwell = 8'd2; last = 4'd3; sel = 4'd0; load = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      load  = 1'b0;
      exp_y = 16'h0001 << exp_idx[i];
      exp_w = (i == 12);
      vectors++; if (idx_h !== exp_idx[i][3:0]) begin errors++; $display("FAIL scan_ring_idx[%0d]: got %0d expected %0d", i, idx_h, exp_idx[i]); end
      vectors++; if (y_h !== exp_y) begin errors++; $display("FAIL scan_ring_y[%0d]: got %h expected %h", i, y_h, exp_y); end
      vectors++; if (wrap_h !== exp_w) begin errors++; $display("FAIL scan_ring_wrap[%0d]: got %b expected %b", i, wrap_h, exp_w); end
    end
  endtask

  task automatic test_scan_edges();
    logic [3:0] exp_i;
    dwell = 8'd0; last = 4'd15;
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_i = 4'((i + 1) % 16);
      vectors++; if (idx_h !== exp_i) begin errors++; $display("FAIL scan_full_idx[%0d]: got %0d expected %0d", i, idx_h, exp_i); end
      vectors++; if (wrap_h !== (i == 15)) begin errors++; $display("FAIL scan_full_wrap[%0d]: got %b expected %b", i, wrap_h, (i == 15)); end
    end
    last = 4'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (idx_h !== 4'd0) begin errors++; $display("FAIL scan_last0_idx[%0d]: got %0d expected 0", i, idx_h); end
      vectors++; if (wrap_h !== 1'b1) begin errors++; $display("FAIL scan_last0_wrap[%0d]: got %b expected 1", i, wrap_h); end
    end
  endtask

  task automatic test_load_priority();
    dwell = 8'd0; last = 4'd5; sel = 4'd9; load = 1'b1;
    tick();
    load = 1'b0;
    vectors++; if (idx_h !== 4'd9) begin errors++; $display("FAIL prio_load_idx: got %0d expected 9", idx_h); end
    vectors++; if (wrap_h !== 1'b0) begin errors++; $display("FAIL prio_load_wrap: got %b expected 0", wrap_h); end
    tick();
    vectors++; if (idx_h !== 4'd0) begin errors++; $display("FAIL prio_oor_idx: got %0d expected 0", idx_h); end
    vectors++; if (wrap_h !== 1'b1) begin errors++; $display("FAIL prio_oor_wrap: got %b expected 1", wrap_h); end
    tick();
    vectors++; if (idx_h !== 4'd1) begin errors++; $display("FAIL prio_next_idx: got %0d expected 1", idx_h); end
    vectors++; if (wrap_h !== 1'b0) begin errors++; $display("FAIL prio_next_wrap: got %b expected 0", wrap_h); end
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (y_h !== 16'h0000) begin errors++; $display("FAIL async_reset_y: got %h expected 0000", y_h); end
    vectors++; if (y_l !== 16'hFFFF) begin errors++; $display("FAIL async_reset_y_al: got %h expected ffff", y_l); end
    vectors++; if (idx_h !== 4'd0) begin errors++; $display("FAIL async_reset_idx: got %0d expected 0", idx_h); end
    vectors++; if (active_h !== 1'b0) begin errors++; $display("FAIL async_reset_active: got %b expected 0", active_h); end
    en = 1'b0; mode = 1'b0; load = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_active_low();
    en = 1'b1; mode = 1'b0; sel = 4'd0; load = 1'b1;
    tick();
    load = 1'b0;
    vectors++; if (y_l !== 16'hFFFE) begin errors++; $display("FAIL al_load_y: got %h expected fffe", y_l); end
    vectors++; if (y_h !== 16'h0001) begin errors++; $display("FAIL ah_load_y: got %h expected 0001", y_h); end
    vectors++; if (active_l !== 1'b1) begin errors++; $display("FAIL al_load_active: got %b expected 1", active_l); end
    en = 1'b0;
    tick();
    vectors++; if (y_l !== 16'hFFFF) begin errors++; $display("FAIL al_en_off_y: got %h expected ffff", y_l); end
    vectors++; if (wrap_l !== 1'b0) begin errors++; $display("FAIL al_en_off_wrap: got %b expected 0", wrap_l); end
    vectors++; if (idx_l !== 4'd0) begin errors++; $display("FAIL al_en_off_idx: got %0d expected 0", idx_l); end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan_ring();
    test_scan_edges();
    test_load_priority();
    test_async_reset();
    test_active_low();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
